instr_buffer_nway: RTL
======================

INSTR_BUFFER_NWAY -- requirements
Module: instr_buffer_nway

Interface
REQ-001 The block SHALL have parameter DEPTH, default 32: entry count; power of two; at least PUSH_W+POP_W.
REQ-002 The block SHALL have parameter PUSH_W, default 4: fetch lanes per cycle.
REQ-003 The block SHALL have parameter POP_W, default 2: decode lanes per cycle.
REQ-004 The block SHALL have port clock, input, 1 bit: clock; all state updates on posedge.
REQ-005 The block SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port flush_i, input, 1 bit: mispredict flush.
REQ-007 The block SHALL have port push_valid_i, input, PUSH_W bits: per-lane push request.
REQ-008 The block SHALL have port push_entry_i, input, PUSH_W x FETCH_PACKET: per-lane payload.
REQ-009 The block SHALL have port push_ready_o, output, 1 bit: a push bundle is accepted this cycle.
REQ-010 The block SHALL have port pop_valid_o, output, POP_W bits: the entry on lane i is valid.
REQ-011 The block SHALL have port pop_entry_o, output, POP_W x FETCH_PACKET: oldest-first entries.
REQ-012 The block SHALL have port pop_count_i, input, $clog2(POP_W+1) bits: entries consumed by decode.
REQ-013 The block SHALL have port count_o, output, $clog2(DEPTH)+1 bits: current occupancy.

Function
REQ-014 The block SHALL hold head, tail and count registers and wrap the pointers modulo DEPTH.
REQ-015 The block SHALL drive push_ready_o = (DEPTH - count >= PUSH_W), using only the start-of-cycle count.
REQ-016 The block SHALL accept a bundle only when push_ready_o=1 and at least one push_valid_i bit is set; acceptance is all-or-nothing.
REQ-017 The block SHALL write accepted lanes in ascending lane order, compacted, at tail, tail+1, and so on (lanes with valid=0 are skipped), then advance tail by popcount(push_valid_i).
REQ-018 The block SHALL drive pop_entry_o[i] combinationally as mem[(head+i) mod DEPTH], with pop_valid_o[i] = (i < count).
REQ-019 The block SHALL clamp the number popped to min(pop_count_i, count) and advance head by that amount.
REQ-020 On a simultaneous push and pop, the block SHALL apply both: count_next = count + pushed - popped; slots freed this cycle are not usable until the next cycle.
REQ-021 The block SHALL leave push data off pop_entry_o until the cycle after the write (no bypass; one-cycle latency).
REQ-022 When flush_i=1, the block SHALL set head, tail and count to 0 on the next edge and ignore push and pop that cycle.
REQ-023 The block SHALL make count_o, push_ready_o and pop_valid_o consistent with the flushed state in the cycle after flush.
REQ-024 The block SHALL NOT clear mem on flush or reset; validity derives only from count.
REQ-025 The block SHALL never let count exceed DEPTH or go below 0; an assertion SHALL check this.

Reset
REQ-026 reset SHALL take priority over flush_i.
REQ-027 On reset, the block SHALL set head=0, tail=0, count=0; push_ready_o=1, pop_valid_o=0, count_o=0.
REQ-028 A reset asserted mid-stream SHALL discard all buffered entries, and any push in that cycle SHALL be dropped.

Configuration
REQ-029 When macro IBUF_STATS_EN is defined, the block SHALL add output hwm_o ($clog2(DEPTH)+1 bits): maximum count reached since reset.
REQ-030 When IBUF_STATS_EN is defined, the block SHALL add output stall_cycles_o (32 bits, saturating): cycles with any push_valid_i set and push_ready_o=0.
REQ-031 Both statistics outputs SHALL clear only on reset, not on flush.
REQ-032 When IBUF_STATS_EN is undefined, the ports and registers SHALL be absent and all other behaviour SHALL be identical.

Verification (DEPTH=8, PUSH_W=4, POP_W=2)
REQ-033 Scenario: push valid=1111 entries A-D, then pop_count=2 -> pop_entry shows A,B; next cycle C,D; count goes 4 then 2.
REQ-034 Scenario: push valid=1010 entries X,Y -> stored compacted; pop_entry_o[0]=X, [1]=Y; count=2.
REQ-035 Scenario: count=5 with push valid=1111 -> push_ready_o=0, nothing written, count stays 5; if IBUF_STATS_EN, stall_cycles_o increments by 1.
REQ-036 Scenario: count=4, push 4 and pop_count=2 in the same cycle -> count=6; pointers wrap correctly over 3 cycles of traffic, with order preserved across index 7->0.
REQ-037 Scenario: count=6, flush_i=1 together with push and pop -> next cycle count=0, pop_valid_o=00, push_ready_o=1; hwm_o stays 6.
REQ-038 Scenario: count=1, pop_count=2 -> one entry popped, count=0, pop_valid_o=00; reset during traffic -> count_o=0 next cycle.

Source files
------------

// File: rtl/instr_buffer_nway.sv
// rtl/instr_buffer_nway.sv - multi-lane in-order instruction buffer (PUSH_W in, POP_W out)
// Optional statistics (hwm_o, stall_cycles_o) built when IBUF_STATS_EN is defined.
module instr_buffer_nway #(
    parameter int DEPTH   = 32,
    parameter int PUSH_W  = 4,
    parameter int POP_W   = 2,
    parameter int ENTRY_W = 32
) (
    input  logic                                  clock,
    input  logic                                  reset,
    input  logic                                  flush_i,
    input  logic [PUSH_W-1:0]                     push_valid_i,
    input  logic [PUSH_W-1:0][ENTRY_W-1:0]        push_entry_i,
    output logic                                  push_ready_o,
    output logic [POP_W-1:0]                      pop_valid_o,
    output logic [POP_W-1:0][ENTRY_W-1:0]         pop_entry_o,
    input  logic [$clog2(POP_W+1)-1:0]            pop_count_i,
    output logic [$clog2(DEPTH):0]                count_o
`ifdef IBUF_STATS_EN
    ,
    output logic [$clog2(DEPTH):0]                hwm_o,
    output logic [31:0]                           stall_cycles_o
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   head;
    logic [PTR_W-1:0]   tail;
    logic [CNT_W-1:0]   count;

    logic [PTR_W-1:0]   lane_off [PUSH_W];
    logic [CNT_W-1:0]   push_n;
    logic [CNT_W-1:0]   pop_n;
    logic [CNT_W-1:0]   push_acc_n;
    logic [CNT_W-1:0]   count_next;
    logic               push_fire;

    assign push_ready_o = (CNT_W'(DEPTH) - count) >= CNT_W'(PUSH_W);
    assign push_fire    = push_ready_o && (|push_valid_i);
    assign count_o      = count;

    // Each valid lane lands at tail plus the number of valid lanes below it.
    always_comb begin
        push_n = '0;
        for (int i = 0; i < PUSH_W; i++) begin
            lane_off[i] = push_n[PTR_W-1:0];
            if (push_valid_i[i])
                push_n = push_n + CNT_W'(1);
        end
    end

    always_comb begin
        pop_n      = (CNT_W'(pop_count_i) < count) ? CNT_W'(pop_count_i) : count;
        push_acc_n = push_fire ? push_n : '0;
        count_next = count + push_acc_n - pop_n;
    end

    always_comb begin
        for (int i = 0; i < POP_W; i++) begin
            pop_valid_o[i] = CNT_W'(i) < count;
            pop_entry_o[i] = mem[head + PTR_W'(i)];
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush_i) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + pop_n[PTR_W-1:0];
            tail  <= tail + push_acc_n[PTR_W-1:0];
            count <= count_next;
        end
    end

    // Storage is never cleared; validity comes only from count.
    always_ff @(posedge clock) begin
        if (!reset && !flush_i && push_fire) begin
            for (int i = 0; i < PUSH_W; i++) begin
                if (push_valid_i[i])
                    mem[tail + lane_off[i]] <= push_entry_i[i];
            end
        end
    end

`ifdef IBUF_STATS_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            hwm_o          <= '0;
            stall_cycles_o <= '0;
        end else begin
            if (!flush_i && count_next > hwm_o)
                hwm_o <= count_next;
            if ((|push_valid_i) && !push_ready_o && (stall_cycles_o != 32'hFFFF_FFFF))
                stall_cycles_o <= stall_cycles_o + 32'd1;
        end
    end
`endif

    count_bound: assert property (@(posedge clock) disable iff (reset) count <= CNT_W'(DEPTH));

endmodule
